// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and state encoding for the two-port memory arbiter.
// Fetch and data ports share one single-outstanding memory bus.
package mem_port_arbiter_pkg;

    localparam int MPA_DATA_WIDTH = 32;
    localparam int MPA_ADDR_WIDTH = 32;

    // state        | meaning
    // ARB_IDLE     | no access outstanding, arbitrate and drive the bus request
    // ARB_WAIT_IF  | fetch access granted, waiting for bus_rvalid_i
    // ARB_WAIT_DM  | data access granted, waiting for bus_rvalid_i
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT_IF = 2'd1,
        ARB_WAIT_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one shared memory bus, one access
// in flight at a time, with a bounded data burst so fetch cannot starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = mem_port_arbiter_pkg::MPA_DATA_WIDTH,
    parameter int ADDR_WIDTH   = mem_port_arbiter_pkg::MPA_ADDR_WIDTH,
    parameter int MAX_DM_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,

    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [3:0]            dm_be_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,

    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [3:0]            bus_be_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,

    output logic                  spurious_o
);

    localparam int                  STREAK_W   = $clog2(MAX_DM_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_BURST);

    arb_state_e            state, state_nxt;
    logic [STREAK_W-1:0]   dm_streak, dm_streak_nxt;
    logic                  if_wins, dm_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            dm_streak <= '0;
        end else begin
            state     <= state_nxt;
            dm_streak <= dm_streak_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dm_streak_nxt = dm_streak;
        if_wins       = 1'b0;
        dm_wins       = 1'b0;
        if_gnt_o      = 1'b0;
        dm_gnt_o      = 1'b0;
        if_rvalid_o   = 1'b0;
        dm_rvalid_o   = 1'b0;
        if_rdata_o    = '0;
        dm_rdata_o    = '0;
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_be_o      = 4'h0;
        bus_addr_o    = '0;
        bus_wdata_o   = '0;
        spurious_o    = 1'b0;

        unique case (state)
            ARB_IDLE: begin
                // Fetch only overtakes a pending data request once the burst budget is spent.
                if_wins = !rst && if_req_i && (!dm_req_i || (dm_streak == STREAK_MAX));
                dm_wins = !rst && !if_wins && dm_req_i;

                if (if_wins) begin
                    bus_req_o  = 1'b1;
                    bus_be_o   = 4'hF;
                    bus_addr_o = if_addr_i;
                end else if (dm_wins) begin
                    bus_req_o   = 1'b1;
                    bus_we_o    = dm_we_i;
                    bus_be_o    = dm_be_i;
                    bus_addr_o  = dm_addr_i;
                    bus_wdata_o = dm_wdata_i;
                end

                if_gnt_o = bus_gnt_i && if_wins;
                dm_gnt_o = bus_gnt_i && dm_wins;

                if (if_gnt_o) begin
                    state_nxt     = ARB_WAIT_IF;
                    dm_streak_nxt = '0;
                end else if (dm_gnt_o) begin
                    state_nxt = ARB_WAIT_DM;
                    if (!if_req_i)
                        dm_streak_nxt = '0;
                    else if (dm_streak != STREAK_MAX)
                        dm_streak_nxt = dm_streak + 1'b1;
                end

                // Nothing is outstanding, so any response here is stale or bogus.
                spurious_o = bus_rvalid_i;
            end

            ARB_WAIT_IF: begin
                if (bus_rvalid_i) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = bus_rdata_i;
                    state_nxt   = ARB_IDLE;
                end
            end

            ARB_WAIT_DM: begin
                if (bus_rvalid_i) begin
                    dm_rvalid_o = 1'b1;
                    dm_rdata_o  = bus_rdata_i;
                    state_nxt   = ARB_IDLE;
                end
            end

            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule
